// File: rtl/dlx_id_hazard_pipe_if.sv
// ID back-end bundle: IF/ID fields, forwarding
// sources, control and the ID/EX register outputs.
interface dlx_id_hazard_pipe_if #(
  parameter int W    = 32,
  parameter int RA   = 5,
  parameter int NFWD = 2
);
  logic            dc_wait;
  logic            flush;
  logic            in_valid;
  logic [W-1:0]    in_npc;
  logic [RA-1:0]   in_rs1;
  logic [RA-1:0]   in_rs2;
  logic            in_use_rs2;
  logic [RA-1:0]   in_rd;
  logic            in_reg_wen;
  logic            in_is_load;
  logic [1:0]      in_br_mode;
  logic [W-1:0]    in_imm;
  logic [W-1:0]    rf_a;
  logic [W-1:0]    rf_b;
  logic [NFWD-1:0] fwd_valid;
  logic [NFWD*RA-1:0] fwd_rd;
  logic [NFWD*W-1:0]  fwd_data;
  logic            id_stall;
  logic            id_cond;
  logic [W-1:0]    id_target;
  logic            ex_valid;
  logic [W-1:0]    ex_a;
  logic [W-1:0]    ex_b;
  logic [W-1:0]    ex_imm;
  logic [W-1:0]    ex_npc;
  logic [RA-1:0]   ex_rd;
  logic            ex_reg_wen;
  logic            ex_is_load;

  modport master (
    output dc_wait, flush, in_valid, in_npc,
    output in_rs1, in_rs2, in_use_rs2, in_rd,
    output in_reg_wen, in_is_load, in_br_mode,
    output in_imm, rf_a, rf_b,
    output fwd_valid, fwd_rd, fwd_data,
    input  id_stall, id_cond, id_target,
    input  ex_valid, ex_a, ex_b, ex_imm, ex_npc,
    input  ex_rd, ex_reg_wen, ex_is_load
  );

  modport slave (
    input  dc_wait, flush, in_valid, in_npc,
    input  in_rs1, in_rs2, in_use_rs2, in_rd,
    input  in_reg_wen, in_is_load, in_br_mode,
    input  in_imm, rf_a, rf_b,
    input  fwd_valid, fwd_rd, fwd_data,
    output id_stall, id_cond, id_target,
    output ex_valid, ex_a, ex_b, ex_imm, ex_npc,
    output ex_rd, ex_reg_wen, ex_is_load
  );
endinterface

// File: rtl/dlx_id_hazard_pipe.sv
// DLX decode back end: operand forwarding, branch
// resolution, load/branch-use interlock, ID/EX register.
module dlx_id_hazard_pipe #(
  parameter int W        = 32,
  parameter int RA       = 5,
  parameter int NFWD     = 2,
  parameter int LOAD_LAT = 1
) (
  input logic clk,
  input logic rst,
  dlx_id_hazard_pipe_if.slave bus
);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t       state, state_d;
  logic [2:0]   cnt, cnt_d;
  logic [W-1:0] op_a, op_b;
  logic         load_use, br_use, hazard;
  logic [2:0]   stall_len;
  logic         cond;
  logic         bubble, issue;

  // Priority forwarding: lowest source index wins, r0 never forwarded
  always_comb begin
    op_a = bus.rf_a;
    op_b = bus.rf_b;
    for (int j = NFWD - 1; j >= 0; j--) begin
      if (bus.fwd_valid[j] && bus.in_rs1 != '0 &&
          bus.fwd_rd[j*RA +: RA] == bus.in_rs1)
        op_a = bus.fwd_data[j*W +: W];
      if (bus.fwd_valid[j] && bus.in_rs2 != '0 &&
          bus.fwd_rd[j*RA +: RA] == bus.in_rs2)
        op_b = bus.fwd_data[j*W +: W];
    end
  end

  // Hazard detection against the instruction sitting in ID/EX
  always_comb begin
    load_use = bus.in_valid && bus.ex_valid &&
               bus.ex_is_load && bus.ex_reg_wen &&
               bus.ex_rd != '0 &&
               (bus.ex_rd == bus.in_rs1 ||
                (bus.in_use_rs2 &&
                 bus.ex_rd == bus.in_rs2));
    br_use   = bus.in_valid && bus.in_br_mode != 2'b00 &&
               bus.ex_valid && bus.ex_reg_wen &&
               !bus.ex_is_load && bus.ex_rd != '0 &&
               bus.ex_rd == bus.in_rs1;
    hazard    = state == S_IDLE && (load_use || br_use);
    stall_len = load_use ? 3'(LOAD_LAT) : 3'd1;
  end

  // Branch condition on the forwarded rs1 operand
  always_comb begin
    cond = 1'b0;
    unique case (bus.in_br_mode)
      2'b01:   cond = op_a == '0;
      2'b10:   cond = op_a != '0;
      2'b11:   cond = 1'b1;
      default: cond = 1'b0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // FSM next state: flush beats freeze beats interlock
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    if (bus.flush) begin
      state_d = S_IDLE;
      cnt_d   = 3'd0;
    end else if (!bus.dc_wait) begin
      unique case (state)
        S_WAIT: begin
          cnt_d = cnt - 3'd1;
          if (cnt <= 3'd1)
            state_d = S_IDLE;
        end
        default: begin
          if (hazard) begin
            cnt_d   = stall_len - 3'd1;
            state_d = stall_len > 3'd1 ? S_WAIT : S_IDLE;
          end
        end
      endcase
    end
  end

  // FSM outputs: stall, branch redirect, bubble/issue strobes
  always_comb begin
    bubble = !bus.flush && !bus.dc_wait &&
             (state == S_WAIT || hazard);
    issue  = !bus.flush && !bus.dc_wait &&
             state == S_IDLE && !hazard;
    bus.id_stall  = bus.dc_wait ||
                    (!bus.flush &&
                     (state == S_WAIT || hazard));
    bus.id_cond   = bus.in_valid && cond &&
                    !bus.id_stall && !bus.flush;
    bus.id_target = bus.in_npc + bus.in_imm;
  end

  // ID/EX register; bubbles only clear the valid bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.ex_valid   <= 1'b0;
      bus.ex_a       <= '0;
      bus.ex_b       <= '0;
      bus.ex_imm     <= '0;
      bus.ex_npc     <= '0;
      bus.ex_rd      <= '0;
      bus.ex_reg_wen <= 1'b0;
      bus.ex_is_load <= 1'b0;
    end else if (bus.flush || bubble) begin
      bus.ex_valid <= 1'b0;
    end else if (issue) begin
      bus.ex_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.ex_a       <= op_a;
        bus.ex_b       <= op_b;
        bus.ex_imm     <= bus.in_imm;
        bus.ex_npc     <= bus.in_npc;
        bus.ex_rd      <= bus.in_rd;
        bus.ex_reg_wen <= bus.in_reg_wen;
        bus.ex_is_load <= bus.in_is_load;
      end
    end
  end

endmodule

// File: tb/tb_dlx_id_hazard_pipe.sv
// Scoreboard bench for the DLX ID back end:
// directed vectors, queued ID/EX expectations.
module tb_dlx_id_hazard_pipe;

  logic clk;
  logic rst;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [31:0] npc;
    logic [4:0]  rd;
    logic        wen;
    logic        ld;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  dlx_id_hazard_pipe_if #(.W(32), .RA(5), .NFWD(2)) bus();

  dlx_id_hazard_pipe #(
    .W(32), .RA(5), .NFWD(2), .LOAD_LAT(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic clr();
    bus.in_valid   = 1'b0;
    bus.in_npc     = '0;
    bus.in_rs1     = '0;
    bus.in_rs2     = '0;
    bus.in_use_rs2 = 1'b0;
    bus.in_rd      = '0;
    bus.in_reg_wen = 1'b0;
    bus.in_is_load = 1'b0;
    bus.in_br_mode = 2'b00;
    bus.in_imm     = '0;
    bus.rf_a       = '0;
    bus.rf_b       = '0;
    bus.fwd_valid  = '0;
    bus.fwd_rd     = '0;
    bus.fwd_data   = '0;
  endtask

  task automatic set_ins(
    input logic [31:0] npc,
    input logic [4:0]  rs1, rs2,
    input logic        use2,
    input logic [4:0]  rd,
    input logic        wen, ld,
    input logic [1:0]  br,
    input logic [31:0] imm, rfa, rfb);
    bus.in_valid   = 1'b1;
    bus.in_npc     = npc;
    bus.in_rs1     = rs1;
    bus.in_rs2     = rs2;
    bus.in_use_rs2 = use2;
    bus.in_rd      = rd;
    bus.in_reg_wen = wen;
    bus.in_is_load = ld;
    bus.in_br_mode = br;
    bus.in_imm     = imm;
    bus.rf_a       = rfa;
    bus.rf_b       = rfb;
    bus.fwd_valid  = '0;
  endtask

  task automatic fwd(input logic [1:0] fv,
                     input logic [4:0] rd1, rd0,
                     input logic [31:0] d1, d0);
    bus.fwd_valid = fv;
    bus.fwd_rd    = {rd1, rd0};
    bus.fwd_data  = {d1, d0};
  endtask

  task automatic push(input logic [31:0] a, b, imm, npc,
                      input logic [4:0] rd,
                      input logic wen, ld);
    exp_t e;
    e = '{a: a, b: b, imm: imm, npc: npc,
          rd: rd, wen: wen, ld: ld};
    q.push_back(e);
  endtask

  // Monitor: every non-frozen edge that leaves ex_valid
  // high is a fresh issue and must match the queue head.
  initial begin
    logic dw, fl, rs;
    exp_t e, act;
    forever begin
      @(posedge clk);
      dw = bus.dc_wait;
      fl = bus.flush;
      rs = rst;
      #1;
      if (!dw && !fl && !rs && !rst && bus.ex_valid) begin
        act = '{a: bus.ex_a, b: bus.ex_b,
                imm: bus.ex_imm, npc: bus.ex_npc,
                rd: bus.ex_rd, wen: bus.ex_reg_wen,
                ld: bus.ex_is_load};
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_issue: got %h expected none",
                   act);
        end else begin
          e = q.pop_front();
          if (act !== e) begin
            n_fail++;
            $display("FAIL ex_issue: got %h expected %h",
                     act, e);
          end
        end
      end
    end
  end

  initial begin
    rst         = 1'b1;
    bus.dc_wait = 1'b0;
    bus.flush   = 1'b0;
    clr();
    bus.in_npc = 32'h10;
    bus.in_imm = 32'h4;
    @(negedge clk);
    chk("rst_ex_valid", 64'(bus.ex_valid), 64'd0);
    chk("rst_ex_a", 64'(bus.ex_a), 64'd0);
    chk("rst_ex_npc", 64'(bus.ex_npc), 64'd0);
    chk("rst_ex_rd", 64'(bus.ex_rd), 64'd0);
    chk("rst_stall", 64'(bus.id_stall), 64'd0);
    chk("rst_cond", 64'(bus.id_cond), 64'd0);
    chk("rst_target", 64'(bus.id_target), 64'h14);
    bus.dc_wait = 1'b1;
    #1 chk("rst_stall_dcw", 64'(bus.id_stall), 64'd1);
    bus.dc_wait = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // forwarding priority: source 0 beats source 1
    set_ins(32'h40, 5'd3, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0,
            2'b00, 32'h10, 32'h1111, 32'h2222);
    fwd(2'b11, 5'd3, 5'd3, 32'hBBBB, 32'hAAAA);
    #1 chk("fwd_stall", 64'(bus.id_stall), 64'd0);
    push(32'hAAAA, 32'h2222, 32'h10, 32'h40, 5'd1, 1, 0);
    @(negedge clk);

    // r0 never forwarded; rs2 taken from source 1
    set_ins(32'h44, 5'd0, 5'd3, 1'b1, 5'd2, 1'b1, 1'b0,
            2'b00, 32'h20, 32'h1111, 32'h2222);
    fwd(2'b10, 5'd3, 5'd3, 32'hBBBB, 32'hAAAA);
    push(32'h1111, 32'hBBBB, 32'h20, 32'h44, 5'd2, 1, 0);
    @(negedge clk);

    // LW r5
    set_ins(32'h48, 5'd6, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1,
            2'b00, 32'h8, 32'h300, 32'h2222);
    push(32'h300, 32'h2222, 32'h8, 32'h48, 5'd5, 1, 1);
    @(negedge clk);

    // ADD r7,r5,r2: three stall cycles, three bubbles
    set_ins(32'h4C, 5'd5, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0,
            2'b00, 32'h0, 32'h999, 32'h22);
    fwd(2'b01, 5'd0, 5'd5, 32'h0, 32'h55);
    for (int k = 0; k < 3; k++) begin
      #1 chk("lu_stall", 64'(bus.id_stall), 64'd1);
      @(negedge clk);
      chk("lu_bubble", 64'(bus.ex_valid), 64'd0);
      chk("lu_hold_a", 64'(bus.ex_a), 64'h300);
    end
    #1 chk("lu_release", 64'(bus.id_stall), 64'd0);
    push(32'h55, 32'h22, 32'h0, 32'h4C, 5'd7, 1, 0);
    @(negedge clk);

    // ADD r4
    set_ins(32'h50, 5'd1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0,
            2'b00, 32'h0, 32'h9, 32'h0);
    #1 chk("add4_stall", 64'(bus.id_stall), 64'd0);
    push(32'h9, 32'h0, 32'h0, 32'h50, 5'd4, 1, 0);
    @(negedge clk);

    // BEQZ r4: one stall cycle, then taken
    set_ins(32'h100, 5'd4, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0,
            2'b01, 32'hFFFFFFF8, 32'h77, 32'h0);
    fwd(2'b01, 5'd0, 5'd4, 32'h0, 32'h0);
    #1;
    chk("bu_stall", 64'(bus.id_stall), 64'd1);
    chk("bu_cond_stalled", 64'(bus.id_cond), 64'd0);
    chk("bu_target", 64'(bus.id_target), 64'hF8);
    @(negedge clk);
    chk("bu_bubble", 64'(bus.ex_valid), 64'd0);
    #1;
    chk("bu_stall_done", 64'(bus.id_stall), 64'd0);
    chk("bu_cond", 64'(bus.id_cond), 64'd1);
    chk("bu_target2", 64'(bus.id_target), 64'hF8);
    push(32'h0, 32'h0, 32'hFFFFFFF8, 32'h100, 5'd0, 0, 0);
    @(negedge clk);

    // BNEZ r4 with r4==0: not taken
    set_ins(32'h104, 5'd4, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0,
            2'b10, 32'h20, 32'h77, 32'h0);
    fwd(2'b01, 5'd0, 5'd4, 32'h0, 32'h0);
    #1 chk("bnez_cond", 64'(bus.id_cond), 64'd0);
    push(32'h0, 32'h0, 32'h20, 32'h104, 5'd0, 0, 0);
    @(negedge clk);

    // unconditional jump
    set_ins(32'h108, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0,
            2'b11, 32'h8, 32'h0, 32'h0);
    #1;
    chk("j_cond", 64'(bus.id_cond), 64'd1);
    chk("j_target", 64'(bus.id_target), 64'h110);
    push(32'h0, 32'h0, 32'h8, 32'h108, 5'd0, 0, 0);
    @(negedge clk);

    // freeze in the middle of a load-use wait
    set_ins(32'h200, 5'd6, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1,
            2'b00, 32'h4, 32'h600, 32'h0);
    push(32'h600, 32'h0, 32'h4, 32'h200, 5'd5, 1, 1);
    @(negedge clk);
    set_ins(32'h204, 5'd5, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0,
            2'b00, 32'h0, 32'h0, 32'h0);
    fwd(2'b01, 5'd0, 5'd5, 32'h0, 32'h66);
    #1 chk("fz_stall0", 64'(bus.id_stall), 64'd1);
    @(negedge clk);
    bus.dc_wait = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1 chk("fz_stall", 64'(bus.id_stall), 64'd1);
      @(negedge clk);
      chk("fz_valid", 64'(bus.ex_valid), 64'd0);
      chk("fz_hold_npc", 64'(bus.ex_npc), 64'h200);
    end
    bus.dc_wait = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1 chk("fz_rest_stall", 64'(bus.id_stall), 64'd1);
      @(negedge clk);
      chk("fz_rest_bubble", 64'(bus.ex_valid), 64'd0);
    end
    #1 chk("fz_release", 64'(bus.id_stall), 64'd0);
    push(32'h66, 32'h0, 32'h0, 32'h204, 5'd7, 1, 0);
    @(negedge clk);

    // flush while waiting with cnt=2
    set_ins(32'h300, 5'd6, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1,
            2'b00, 32'h4, 32'h700, 32'h0);
    push(32'h700, 32'h0, 32'h4, 32'h300, 5'd5, 1, 1);
    @(negedge clk);
    set_ins(32'h304, 5'd5, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0,
            2'b00, 32'h0, 32'h0, 32'h0);
    fwd(2'b01, 5'd0, 5'd5, 32'h0, 32'h77);
    #1 chk("fl_stall0", 64'(bus.id_stall), 64'd1);
    @(negedge clk);
    bus.flush = 1'b1;
    #1 chk("fl_stall_in_flush", 64'(bus.id_stall), 64'd0);
    @(negedge clk);
    bus.flush = 1'b0;
    chk("fl_valid", 64'(bus.ex_valid), 64'd0);
    #1 chk("fl_idle", 64'(bus.id_stall), 64'd0);
    push(32'h77, 32'h0, 32'h0, 32'h304, 5'd7, 1, 0);
    @(negedge clk);

    // flush together with dc_wait still kills ID/EX
    set_ins(32'h400, 5'd1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0,
            2'b00, 32'h0, 32'h11, 32'h0);
    bus.flush   = 1'b1;
    bus.dc_wait = 1'b1;
    #1 chk("fdw_stall", 64'(bus.id_stall), 64'd1);
    @(negedge clk);
    chk("fdw_valid", 64'(bus.ex_valid), 64'd0);
    bus.flush   = 1'b0;
    bus.dc_wait = 1'b0;
    clr();
    @(negedge clk);

    // asynchronous reset during an interlock
    set_ins(32'h500, 5'd6, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1,
            2'b00, 32'h4, 32'h800, 32'h0);
    push(32'h800, 32'h0, 32'h4, 32'h500, 5'd5, 1, 1);
    @(negedge clk);
    set_ins(32'h504, 5'd5, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0,
            2'b00, 32'h0, 32'h0, 32'h0);
    fwd(2'b01, 5'd0, 5'd5, 32'h0, 32'h88);
    #1 chk("ar_stall0", 64'(bus.id_stall), 64'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", 64'(bus.ex_valid), 64'd0);
    chk("ar_a", 64'(bus.ex_a), 64'd0);
    chk("ar_npc", 64'(bus.ex_npc), 64'd0);
    chk("ar_imm", 64'(bus.ex_imm), 64'd0);
    chk("ar_rd", 64'(bus.ex_rd), 64'd0);
    chk("ar_load", 64'(bus.ex_is_load), 64'd0);
    chk("ar_stall", 64'(bus.id_stall), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    push(32'h88, 32'h0, 32'h0, 32'h504, 5'd7, 1, 0);
    @(negedge clk);
    clr();
    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
